// File: rtl/cache_mem_arbiter.sv
// Arbitrates a single-ported memory bus between icache fills and dcache fills/writebacks.
// Define ARB_STARVATION_GUARD_EN to bound consecutive dcache grants while icache is waiting.
module cache_mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        icache_mem_REN,
  input  logic [31:0] icache_mem_addr,
  output logic        icache_mem_ready,
  output logic [31:0] icache_mem_load,
  input  logic        dcache_mem_REN,
  input  logic        dcache_mem_WEN,
  input  logic [31:0] dcache_mem_addr,
  input  logic [31:0] dcache_mem_store,
  output logic        dcache_mem_ready,
  output logic [31:0] dcache_mem_load,
  output logic        mem_REN,
  output logic        mem_WEN,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store,
  input  logic        mem_ready,
  input  logic [31:0] mem_load
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state, next_state;
  logic   i_req, d_req, guard_fire;

  assign i_req = icache_mem_REN;
  assign d_req = dcache_mem_REN | dcache_mem_WEN;

`ifdef ARB_STARVATION_GUARD_EN
  logic [3:0] streak;

  assign guard_fire = (streak == 4'(MAX_D_STREAK));

  // Streak only moves on grants issued from IDLE; it can never pass MAX_D_STREAK.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (next_state == GNT_I)
        streak <= '0;
      else if (next_state == GNT_D)
        streak <= i_req ? streak + 4'd1 : 4'd0;
    end
  end
`else
  assign guard_fire = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= next_state;
  end

  // A grant ends on completion or when the requester withdraws (abort).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_req && i_req)
          next_state = guard_fire ? GNT_I : GNT_D;
        else if (d_req)
          next_state = GNT_D;
        else if (i_req)
          next_state = GNT_I;
      end
      GNT_I: if (mem_ready || !i_req) next_state = IDLE;
      GNT_D: if (mem_ready || !d_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    icache_mem_ready = 1'b0;
    icache_mem_load  = '0;
    dcache_mem_ready = 1'b0;
    dcache_mem_load  = '0;
    mem_REN          = 1'b0;
    mem_WEN          = 1'b0;
    mem_addr         = '0;
    mem_store        = '0;
    case (state)
      GNT_I: begin
        mem_REN          = icache_mem_REN;
        mem_addr         = icache_mem_addr;
        icache_mem_ready = mem_ready;
        icache_mem_load  = mem_load;
      end
      GNT_D: begin
        mem_WEN          = dcache_mem_WEN;
        mem_REN          = dcache_mem_REN & ~dcache_mem_WEN;
        mem_addr         = dcache_mem_addr;
        mem_store        = dcache_mem_store;
        dcache_mem_ready = mem_ready;
        dcache_mem_load  = mem_load;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboarded bench for cache_mem_arbiter: expected completions are queued as stimulus is
// driven and compared whenever either cache sees ready.
module tb_cache_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        icache_mem_REN;
  logic [31:0] icache_mem_addr;
  logic        icache_mem_ready;
  logic [31:0] icache_mem_load;
  logic        dcache_mem_REN;
  logic        dcache_mem_WEN;
  logic [31:0] dcache_mem_addr;
  logic [31:0] dcache_mem_store;
  logic        dcache_mem_ready;
  logic [31:0] dcache_mem_load;
  logic        mem_REN;
  logic        mem_WEN;
  logic [31:0] mem_addr;
  logic [31:0] mem_store;
  logic        mem_ready;
  logic [31:0] mem_load;

  typedef struct {
    bit          d_side;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } txn_t;

  txn_t expq[$];
  int   checks = 0;
  int   passes = 0;

  cache_mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .icache_mem_REN(icache_mem_REN), .icache_mem_addr(icache_mem_addr),
    .icache_mem_ready(icache_mem_ready), .icache_mem_load(icache_mem_load),
    .dcache_mem_REN(dcache_mem_REN), .dcache_mem_WEN(dcache_mem_WEN),
    .dcache_mem_addr(dcache_mem_addr), .dcache_mem_store(dcache_mem_store),
    .dcache_mem_ready(dcache_mem_ready), .dcache_mem_load(dcache_mem_load),
    .mem_REN(mem_REN), .mem_WEN(mem_WEN), .mem_addr(mem_addr), .mem_store(mem_store),
    .mem_ready(mem_ready), .mem_load(mem_load)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected)
      passes++;
    else
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic i_ren, input logic [31:0] i_addr,
                               input logic d_ren, input logic d_wen, input logic [31:0] d_addr,
                               input logic [31:0] d_store, input logic m_ready, input logic [31:0] m_load);
    icache_mem_REN   = i_ren;
    icache_mem_addr  = i_addr;
    dcache_mem_REN   = d_ren;
    dcache_mem_WEN   = d_wen;
    dcache_mem_addr  = d_addr;
    dcache_mem_store = d_store;
    mem_ready        = m_ready;
    mem_load         = m_load;
  endtask

  task automatic pushTxn(input bit d_side, input bit wen, input logic [31:0] addr,
                         input logic [31:0] store, input logic [31:0] load);
    txn_t t;
    t.d_side = d_side;
    t.wen    = wen;
    t.addr   = addr;
    t.store  = store;
    t.load   = load;
    expq.push_back(t);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleCheck(input string tag);
    @(negedge CLK);
    checkOutput({tag, "_strobes"}, {30'd0, mem_REN, mem_WEN}, 32'd0);
    checkOutput({tag, "_readys"}, {30'd0, icache_mem_ready, dcache_mem_ready}, 32'd0);
    checkOutput({tag, "_addr"}, mem_addr, 32'd0);
    #1;
  endtask

  // Every ready seen by either cache must match the oldest queued transaction.
  always @(negedge CLK) begin
    if (icache_mem_ready === 1'b1 || dcache_mem_ready === 1'b1) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_ready", {30'd0, icache_mem_ready, dcache_mem_ready}, 32'd0);
      end else begin
        txn_t e;
        e = expq.pop_front();
        checkOutput("sb_side", {30'd0, icache_mem_ready, dcache_mem_ready}, e.d_side ? 32'd1 : 32'd2);
        checkOutput("sb_wen", {31'd0, mem_WEN}, {31'd0, e.wen});
        checkOutput("sb_ren", {31'd0, mem_REN}, {31'd0, !e.wen});
        checkOutput("sb_addr", mem_addr, e.addr);
        checkOutput("sb_store", mem_store, e.store);
        checkOutput("sb_load", e.d_side ? dcache_mem_load : icache_mem_load, e.load);
        checkOutput("sb_other_load", e.d_side ? icache_mem_load : dcache_mem_load, 32'd0);
      end
    end
  end

  initial begin
    // Reset held for two edges with both sides requesting and memory claiming ready.
    nRST = 1'b0;
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0BAD0BAD);
    tick;
    tick;
    @(negedge CLK);
    checkOutput("rst_strobes", {30'd0, mem_REN, mem_WEN}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_store", mem_store, 32'd0);
    checkOutput("rst_readys", {30'd0, icache_mem_ready, dcache_mem_ready}, 32'd0);
    checkOutput("rst_iload", icache_mem_load, 32'd0);
    checkOutput("rst_dload", dcache_mem_load, 32'd0);
    #1;
    nRST      = 1'b1;
    mem_ready = 1'b0;
    tick;
    pushTxn(1'b1, 1'b0, 32'h200, 32'h0, 32'hA5A50001);
    mem_ready = 1'b1;
    mem_load  = 32'hA5A50001;
    @(negedge CLK);
    checkOutput("post_rst_grant_d", {31'd0, dcache_mem_ready}, 32'd1);
    tick;
    dcache_mem_REN = 1'b0;
    mem_ready      = 1'b0;
    idleCheck("rst_turn");
    pushTxn(1'b0, 1'b0, 32'h100, 32'h0, 32'h11110001);
    tick;
    mem_ready = 1'b1;
    mem_load  = 32'h11110001;
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idleCheck("rst_i_turn");

    // Single icache read completing on its third grant cycle.
    pushTxn(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    icache_mem_REN  = 1'b1;
    icache_mem_addr = 32'h40;
    tick;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        mem_ready = 1'b1;
        mem_load  = 32'hDEADBEEF;
      end
      @(negedge CLK);
      checkOutput("iread_ren", {31'd0, mem_REN}, 32'd1);
      checkOutput("iread_addr", mem_addr, 32'h40);
      if (c < 3) checkOutput("iread_wait", {31'd0, icache_mem_ready}, 32'd0);
      tick;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idleCheck("iread_turn");

    // Tie with a dcache REN+WEN request: dcache wins and writes, then icache follows.
    pushTxn(1'b1, 1'b1, 32'h80, 32'h1234, 32'h5555AAAA);
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b1, 32'h80, 32'h1234, 1'b0, 32'h0);
    tick;
    mem_ready = 1'b1;
    mem_load  = 32'h5555AAAA;
    @(negedge CLK);
    checkOutput("tie_wen", {31'd0, mem_WEN}, 32'd1);
    checkOutput("tie_ren", {31'd0, mem_REN}, 32'd0);
    tick;
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idleCheck("tie_turn");
    pushTxn(1'b0, 1'b0, 32'h44, 32'h0, 32'h44440044);
    tick;
    mem_ready = 1'b1;
    mem_load  = 32'h44440044;
    @(negedge CLK);
    checkOutput("tie_then_i", {31'd0, mem_REN}, 32'd1);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idleCheck("tie_i_turn");

    // Continuous dcache traffic with immediate ready while icache waits.
`ifdef ARB_STARVATION_GUARD_EN
    for (int k = 0; k < 4; k++) pushTxn(1'b1, 1'b0, 32'h90, 32'h0, 32'h5A5A0000);
    pushTxn(1'b0, 1'b0, 32'h60, 32'h0, 32'h5A5A0000);
`else
    for (int k = 0; k < 5; k++) pushTxn(1'b1, 1'b0, 32'h90, 32'h0, 32'h5A5A0000);
`endif
    applyStimulus(1'b1, 32'h60, 1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 32'h5A5A0000);
    for (int k = 0; k < 10; k++) tick;
`ifdef ARB_STARVATION_GUARD_EN
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
`else
    dcache_mem_REN = 1'b0;
    pushTxn(1'b0, 1'b0, 32'h60, 32'h0, 32'h5A5A0000);
    tick;
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
`endif
    idleCheck("streak_done");

    // Abort: dcache drops WEN mid-grant, then a spurious ready arrives in IDLE.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 32'h77, 1'b0, 32'h0);
    tick;
    @(negedge CLK);
    checkOutput("abort_wen_before", {31'd0, mem_WEN}, 32'd1);
    tick;
    dcache_mem_WEN = 1'b0;
    @(negedge CLK);
    checkOutput("abort_wen", {31'd0, mem_WEN}, 32'd0);
    checkOutput("abort_still_gnt_d", mem_addr, 32'hC0);
    checkOutput("abort_no_ready", {31'd0, dcache_mem_ready}, 32'd0);
    tick;
    mem_ready = 1'b1;
    mem_load  = 32'hFFFF0000;
    idleCheck("spurious1");
    tick;
    idleCheck("spurious2");
    pushTxn(1'b0, 1'b0, 32'h300, 32'h0, 32'h30303030);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick;
    mem_ready = 1'b1;
    mem_load  = 32'h30303030;
    @(negedge CLK);
    checkOutput("after_spurious_grant", {31'd0, mem_REN}, 32'd1);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    idleCheck("final_turn");

    checkOutput("queue_drained", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
